aes_round_ctrl: RTL
===================

# aes_round_ctrl

Iterative AES-128 encryption engine controller. It accepts one 128-bit plaintext block over a valid/ready handshake and holds it in an internal state register. It then sequences NR rounds through a single shared combinational round datapath, requests one round key per round by index, and presents the ciphertext over a second valid/ready handshake. It sits between the USB packet buffer (upstream) and the ciphertext output FIFO (downstream), and requests keys from the precomputed round-key store.

## Interface
- NR, 10, number of AES rounds (10/12/14); round index width is 4 bits for all legal values
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  synchronous active-low reset
- in_valid  in  1  upstream block available
- in_ready  out  1  controller can accept a block
- in_data  in  [0:127]  plaintext; byte 0 = bits [0:7], column-major as in the rest of the datapath
- key_round  out  4  round index of the key needed this cycle
- round_key  in  [0:127]  round key for key_round, combinational from the key store
- key_valid  in  1  round_key is valid; only present when AES_KEY_HANDSHAKE_EN is defined
- out_valid  out  1  ciphertext available
- out_ready  in  1  downstream accepts ciphertext
- out_data  out  [0:127]  ciphertext, equals the state register
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, INIT, ROUND, FINAL, DONE. Round counter rnd is 4 bits. State register st is 128 bits.
- IDLE:
  - in_ready=1.
  - On in_valid: st<=in_data, rnd<=0, go to INIT.
- INIT:
  - key_round=0.
  - st<=st^round_key, rnd<=1, go to ROUND.
- ROUND:
  - key_round=rnd.
  - st<=AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), round_key), rnd<=rnd+1.
  - When rnd==NR-1, go to FINAL.
- FINAL:
  - key_round=NR.
  - Same as ROUND with MixColumns bypassed.
  - Go to DONE.
- DONE:
  - out_valid=1, and st is held.
  - On out_ready go to IDLE.
- in_ready is high only in IDLE and out_valid only in DONE; the two are never high together.
- In IDLE, key_round=0, and st keeps the last ciphertext.
- Reset values: FSM=IDLE, rnd=0, st=0, in_ready=1 after the reset cycle, out_valid=0, busy=0, key_round=0.
- n_rst low in any state aborts the block in flight with no output. The upstream block is not accepted again; upstream must resend.
- in_data changes while not in IDLE are ignored.
- out_data is stable for as long as out_valid is high.

## Timing
- With the accept edge as E0: INIT at E1, rounds 1..NR-1 at E2..E(NR), FINAL at E(NR+1).
- out_valid rises after E(NR+1), which is 11 edges after accept for NR=10.
- Consumption: an edge with out_valid&&out_ready returns the FSM to IDLE. The earliest next accept is the following edge.
- Minimum block period is NR+3 cycles (13 for NR=10).
- key_round and the mix-bypass select are Moore outputs: decoded from FSM/rnd only, with no combinational path from inputs.
- in_ready and out_valid are Moore outputs as well.

## Configuration
- AES_KEY_HANDSHAKE_EN defined:
  - The key_valid port exists.
  - In INIT/ROUND/FINAL, st, rnd and the FSM advance only on edges where key_valid=1. Otherwise everything holds and key_round stays constant.
  - Latency grows by one cycle per stall cycle.
- AES_KEY_HANDSHAKE_EN undefined:
  - No key_valid port.
  - round_key is taken as valid every cycle, giving fixed latency as above.

## Structure
- Shared package aes_pkg holds:
  - typedef for a 128-bit [0:127] block
  - 4-bit round index type
  - FSM state enum
  - localparam NR_AES128=10
- Sub-module aes_round (combinational):
  - Chains the existing subBytes, shiftRows and mixColumns blocks, then XORs the key.
  - Input mix_en; 0 bypasses mixColumns for the final round.
- aes_round_ctrl contains only the FSM, the counter, st and the input mux.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, bench key-store model, in_data 00112233445566778899aabbccddeeff.
  - Required: out_data 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid rising exactly 11 edges after accept.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid.
  - Required: out_data stable, in_ready=0 throughout. The edge with out_ready=1 returns the FSM to IDLE, and in_ready=1 on the next cycle.
- Back-to-back:
  - Stimulus: in_valid held high and out_ready held high, with two blocks (C.1 plaintext, then all-zero).
  - Required: both ciphertexts are correct, and the second accept occurs 13 cycles after the first.
- Key sequencing:
  - Stimulus: monitor key_round over one block.
  - Required: sequence 0,1,...,10, each value held exactly one cycle, then 0 in IDLE.
- Reset mid-operation:
  - Stimulus: n_rst=0 for one edge while in ROUND with rnd=5.
  - Required: next cycle FSM=IDLE, out_valid=0, busy=0, st=0. A fresh C.1 block afterwards yields the correct ciphertext.
- With AES_KEY_HANDSHAKE_EN:
  - Stimulus: key_valid=0 for 3 cycles during round 4.
  - Required: key_round stays at 4 for the stall, out_valid rises after 14 edges, and the ciphertext is still 69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types for the iterative AES-128 engine: block, round index, FSM states and GF(2^8) xtime.
package aes_pkg;

  localparam int NR_AES128 = 10;

  typedef logic [0:127] blk_t;
  typedef logic [3:0]   rnd_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } state_t;

  // Multiply by x in GF(2^8) with the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and key-store bundle for aes_round_ctrl; key_valid exists only with AES_KEY_HANDSHAKE_EN.
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic in_valid;
  logic in_ready;
  blk_t in_data;
  rnd_t key_round;
  blk_t round_key;
`ifdef AES_KEY_HANDSHAKE_EN
  logic key_valid;
`endif
  logic out_valid;
  logic out_ready;
  blk_t out_data;
  logic busy;

`ifdef AES_KEY_HANDSHAKE_EN
  modport master (
    output in_valid, in_data, round_key, key_valid, out_ready,
    input  in_ready, key_round, out_valid, out_data, busy
  );
  modport slave (
    input  in_valid, in_data, round_key, key_valid, out_ready,
    output in_ready, key_round, out_valid, out_data, busy
  );
`else
  modport master (
    output in_valid, in_data, round_key, out_ready,
    input  in_ready, key_round, out_valid, out_data, busy
  );
  modport slave (
    input  in_valid, in_data, round_key, out_ready,
    output in_ready, key_round, out_valid, out_data, busy
  );
`endif

endinterface

// File: rtl/aes_round.sv
// Combinational AES round: SubBytes -> ShiftRows -> MixColumns (bypassed when mix_en=0) -> AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  blk_t st_in,
  input  blk_t round_key,
  input  logic mix_en,
  output blk_t st_out
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 (zero maps to zero), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic blk_t do_round(input blk_t s, input blk_t k, input logic mix);
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];
    logic [7:0] a0, a1, a2, a3;
    blk_t       o;
    o = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[8*i +: 8]);
    // Bytes are column-major: index = 4*col + row; row r rotates left by r columns.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c + r] = sb[4*((c + r) % 4) + r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c + 1];
      a2 = sr[4*c + 2];
      a3 = sr[4*c + 3];
      mc[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = (mix ? mc[i] : sr[i]) ^ k[8*i +: 8];
    return o;
  endfunction

  assign st_out = do_round(st_in, round_key, mix_en);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round controller: FSM, round counter, state register and input mux.
// Optional AES_KEY_HANDSHAKE_EN: rounds advance only on edges where key_valid is high.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input logic             clk,
  input logic             n_rst,
  aes_round_ctrl_if.slave bus
);

  localparam rnd_t RND_LAST  = rnd_t'(NR - 1);
  localparam rnd_t RND_FINAL = rnd_t'(NR);

  state_t state, state_nxt;
  rnd_t   rnd, rnd_nxt;
  blk_t   st, st_nxt;
  blk_t   round_out;
  logic   mix_en;
  logic   adv;

`ifdef AES_KEY_HANDSHAKE_EN
  assign adv = bus.key_valid;
`else
  assign adv = 1'b1;
`endif

  // Moore outputs: decoded from state/rnd only, so the key store sees no input-to-output path.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = st;
  assign mix_en        = (state != FINAL);
  assign bus.key_round = (state == ROUND) ? rnd :
                         (state == FINAL) ? RND_FINAL : '0;

  aes_round u_round (
    .st_in    (st),
    .round_key(bus.round_key),
    .mix_en   (mix_en),
    .st_out   (round_out)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      rnd   <= '0;
      st    <= '0;
    end else begin
      state <= state_nxt;
      rnd   <= rnd_nxt;
      st    <= st_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rnd_nxt   = rnd;
    st_nxt    = st;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          st_nxt    = bus.in_data;
          rnd_nxt   = '0;
          state_nxt = INIT;
        end
      end
      INIT: begin
        if (adv) begin
          st_nxt    = st ^ bus.round_key;
          rnd_nxt   = 4'd1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        if (adv) begin
          st_nxt  = round_out;
          rnd_nxt = rnd + 4'd1;
          if (rnd == RND_LAST) state_nxt = FINAL;
        end
      end
      FINAL: begin
        if (adv) begin
          st_nxt    = round_out;
          rnd_nxt   = rnd + 4'd1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
